// File: rtl/time_slot_generator.sv
// time_slot_generator: divides i_clk into microseconds and microseconds into
// schedule slots. It emits the current slot index, a one-cycle pulse on every
// slot change, and the Qch enqueue/dequeue bank selects derived from the slot
// parity. Slot length and period are sampled only at slot starts, so a
// configuration write never stretches or cuts the slot in progress.
module time_slot_generator #(
  parameter int CYCLES_PER_US = 125
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  iv_hardware_stage,
  input  logic        i_qbv_or_qch,
  input  logic [10:0] iv_time_slot_length,
  input  logic [10:0] iv_schedule_period,
  input  logic        i_time_sync,
  output logic [10:0] ov_time_slot,
  output logic        o_time_slot_switch,
  output logic        o_qch_rx_queue_sel,
  output logic        o_qch_tx_queue_sel
);

  localparam logic [7:0] CYC_LAST = 8'(CYCLES_PER_US - 1);

  logic        en_s;
  logic        start_s;
  logic        boundary_s;
  logic        wrap_s;
  logic [10:0] eff_len_s;
  logic [10:0] eff_per_s;

  logic        en_d_r;
  logic [7:0]  cycle_cnt_r;
  logic [10:0] us_cnt_r;
  logic [10:0] len_l_r;
  logic [10:0] period_l_r;

  logic [7:0]  cycle_nxt_s;
  logic [10:0] us_nxt_s;
  logic [10:0] slot_nxt_s;
  logic [10:0] len_nxt_s;
  logic [10:0] per_nxt_s;
  logic        switch_nxt_s;
  logic        rx_nxt_s;
  logic        tx_nxt_s;

  assign en_s      = (iv_hardware_stage == 3'd3);
  assign start_s   = en_s & ~en_d_r;
  // A zero length or period would make the schedule degenerate; treat it as 1.
  assign eff_len_s = (iv_time_slot_length == 11'd0) ? 11'd1 : iv_time_slot_length;
  assign eff_per_s = (iv_schedule_period == 11'd0) ? 11'd1 : iv_schedule_period;
  assign boundary_s = (cycle_cnt_r == CYC_LAST) && (us_cnt_r == (len_l_r - 11'd1));
  // Wrap either at the end of the current period or when the period about to
  // be latched no longer contains the next slot index.
  assign wrap_s = (ov_time_slot == (period_l_r - 11'd1)) ||
                  (ov_time_slot >= (eff_per_s - 11'd1));

  // Next-state for counters, latched config and outputs.
  always_comb begin
    cycle_nxt_s  = cycle_cnt_r;
    us_nxt_s     = us_cnt_r;
    slot_nxt_s   = ov_time_slot;
    len_nxt_s    = len_l_r;
    per_nxt_s    = period_l_r;
    switch_nxt_s = 1'b0;
    if (!en_s) begin
      cycle_nxt_s = 8'd0;
      us_nxt_s    = 11'd0;
      slot_nxt_s  = 11'd0;
    end else if (start_s || i_time_sync) begin
      cycle_nxt_s  = 8'd0;
      us_nxt_s     = 11'd0;
      slot_nxt_s   = 11'd0;
      len_nxt_s    = eff_len_s;
      per_nxt_s    = eff_per_s;
      switch_nxt_s = 1'b1;
    end else if (boundary_s) begin
      cycle_nxt_s  = 8'd0;
      us_nxt_s     = 11'd0;
      slot_nxt_s   = wrap_s ? 11'd0 : (ov_time_slot + 11'd1);
      len_nxt_s    = eff_len_s;
      per_nxt_s    = eff_per_s;
      switch_nxt_s = 1'b1;
    end else if (cycle_cnt_r == CYC_LAST) begin
      cycle_nxt_s = 8'd0;
      us_nxt_s    = us_cnt_r + 11'd1;
    end else begin
      cycle_nxt_s = cycle_cnt_r + 8'd1;
    end
    rx_nxt_s = en_s & i_qbv_or_qch & slot_nxt_s[0];
    tx_nxt_s = en_s & i_qbv_or_qch & ~slot_nxt_s[0];
  end

  // State and output registers; reset aborts any slot in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_d_r             <= 1'b0;
      cycle_cnt_r        <= 8'd0;
      us_cnt_r           <= 11'd0;
      len_l_r            <= 11'd4;
      period_l_r         <= 11'd2;
      ov_time_slot       <= 11'd0;
      o_time_slot_switch <= 1'b0;
      o_qch_rx_queue_sel <= 1'b0;
      o_qch_tx_queue_sel <= 1'b0;
    end else begin
      en_d_r             <= en_s;
      cycle_cnt_r        <= cycle_nxt_s;
      us_cnt_r           <= us_nxt_s;
      len_l_r            <= len_nxt_s;
      period_l_r         <= per_nxt_s;
      ov_time_slot       <= slot_nxt_s;
      o_time_slot_switch <= switch_nxt_s;
      o_qch_rx_queue_sel <= rx_nxt_s;
      o_qch_tx_queue_sel <= tx_nxt_s;
    end
  end

endmodule
